uart_tx: RTL and testbench

Serial transmitter for the board's USB-serial link: takes one byte per valid/ready handshake and shifts it out on `usb_tx` as an 8-N-1 frame (optionally 8-E-1). It is the outbound counterpart to the inbound serial path and replaces the direct `usb_rx`→`usb_tx` echo in the top level. Sources are the top-level logic (counter value, button events, echo path).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and bit-time helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Truncating division; the receiver must derive its bit time the same way.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-time counter with synchronous clear and end-of-bit tick
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // No tick while held in clear, so an idle transmitter never advances.
    assign o_tick = !i_clear && w_at_last;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-N-1 UART transmitter; define UART_TX_PARITY_EN for 8-E-1 frames
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       block,
    output logic       busy,
    output logic       tx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

    uart_state_t r_state;
    uart_state_t w_state_next;
    logic [7:0]  r_data;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic        r_tx;
    logic        w_tx_next;
    logic        w_accept;
    logic        w_tick;
    logic        w_cnt_clear;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    assign in_ready    = (r_state == ST_IDLE) && !block;
    assign w_accept    = in_valid && in_ready;
    assign busy        = (r_state != ST_IDLE);
    assign tx          = r_tx;
    assign w_cnt_clear = (r_state == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(w_cnt_clear),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b1;
            r_data    <= 8'd0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
            if (w_accept) begin
                r_data   <= in_data;
`ifdef UART_TX_PARITY_EN
                r_parity <= ^in_data;
`endif
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next   = ST_START;
                    w_bit_idx_next = 3'd0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next   = ST_DATA;
                    w_bit_idx_next = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so tx moves on the same edge as the state.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = r_data[w_bit_idx_next];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx at CLK_HZ=1000, BAUD=100
module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       block;
    logic       busy;
    logic       tx;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(
        .CLK_HZ(1000),
        .BAUD  (100)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .block   (block),
        .busy    (busy),
        .tx      (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of frame bit idx: start, 8 data bits LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[3'(idx - 1)];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic send(input logic [7:0] d, input string tag);
        chk({tag, "_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the first negedge after accept; checks ncyc cycles of the frame.
    task automatic check_frame(input logic [7:0] d, input string tag, input int block_at, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            chk({tag, "_tx"}, tx, frame_bit(d, k / CPB));
            chk({tag, "_busy"}, busy, 1);
            if (k == block_at) block = 1'b1;
            in_data = 8'($urandom);
            @(negedge clk);
        end
        if (ncyc == FRAME_CYC) begin
            chk({tag, "_end_busy"}, busy, 0);
            chk({tag, "_end_tx"}, tx, 1);
            chk({tag, "_end_ready"}, in_ready, {31'd0, !block});
        end
    endtask

    task automatic idle_check(input string tag, input int n, input logic exp_ready);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({tag, "_tx"}, tx, 1);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_ready"}, in_ready, {31'd0, exp_ready});
        end
    endtask

    logic   exp_q[$];
    logic [7:0] d;
    logic [7:0] nxt;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        block    = 1'b0;

        // Reset held with a valid byte offered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle_check("post_rst", 3, 1'b1);

        // Single byte
        send(8'hA5, "a5");
        check_frame(8'hA5, "a5", -1, FRAME_CYC);

        // Back-to-back with in_valid held high
        exp_q = {};
        for (int i = 0; i < FRAME_CYC; i++) exp_q.push_back(frame_bit(8'h00, i / CPB));
        exp_q.push_back(1'b1);
        for (int i = 0; i < FRAME_CYC; i++) exp_q.push_back(frame_bit(8'hFF, i / CPB));
        chk("b2b_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        in_data = 8'hFF;
        for (int k = 0; k < exp_q.size(); k++) begin
            chk("b2b_tx", tx, exp_q[k]);
            chk("b2b_busy", busy, (k == FRAME_CYC) ? 0 : 1);
            @(negedge clk);
            if (k == FRAME_CYC) in_valid = 1'b0;
        end
        chk("b2b_end_busy", busy, 0);
        chk("b2b_end_tx", tx, 1);
        idle_check("b2b_idle", 3, 1'b1);

        // Block raised during bit 3
        send(8'h3C, "blk");
        check_frame(8'h3C, "blk", 4 * CPB + 3, FRAME_CYC);
        nxt      = 8'($urandom);
        in_valid = 1'b1;
        in_data  = nxt;
        idle_check("blk_hold", 15, 1'b0);
        block = 1'b0;
        #1;
        chk("blk_fall_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check_frame(nxt, "blk_next", -1, FRAME_CYC);

        // Reset pulse during bit 5
        d = 8'($urandom);
        send(d, "mrst");
        check_frame(d, "mrst", -1, 6 * CPB + 4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_tx", tx, 1);
        chk("mrst_busy", busy, 0);
        rst_n = 1'b1;
        idle_check("mrst_idle", 2 * CPB, 1'b1);
        @(negedge clk);
        send(8'h55, "x55");
        check_frame(8'h55, "x55", -1, FRAME_CYC);

`ifdef UART_TX_PARITY_EN
        send(8'h07, "p07");
        check_frame(8'h07, "p07", -1, FRAME_CYC);
        send(8'h03, "p03");
        check_frame(8'h03, "p03", -1, FRAME_CYC);
`endif

        // Random bytes with random idle gaps
        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom);
            idle_check("rnd_gap", $urandom_range(0, 3), 1'b1);
            send(d, "rnd");
            check_frame(d, "rnd", -1, FRAME_CYC);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
